// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding, grant encoding and default timeout for mem_arbiter
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  localparam int TMO_DEF = 255;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory handshake bundle of the unified-memory arbiter
// master: arbiter view (drives ready/rdata to the stages, mreq/mwe/maddr/mwdata to memory, err)
// slave:  environment view (pipeline stages plus memory)
interface mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic ireq, iready, dreq, dwe, dready, mreq, mwe, mack, err;
  logic [AW-1:0] iaddr, daddr, maddr;
  logic [DW-1:0] irdata, dwdata, drdata, mwdata, mrdata;
  modport master (
    input ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
    output irdata, iready, drdata, dready, mreq, mwe, maddr, mwdata, err
  );
  modport slave (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
    input irdata, iready, drdata, dready, mreq, mwe, maddr, mwdata, err
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data requests
// ports: ireq, dreq (pending requests), last_grant (port served last), gnt (winner)
// MEM_ARB_RR_EN: round-robin on contention; otherwise data always wins and last_grant is unused
module mem_arb_pick import mem_arb_pkg::*; (
  input  logic ireq,
  input  logic dreq,
  input  gnt_t last_grant,
  output gnt_t gnt
);
`ifdef MEM_ARB_RR_EN
  assign gnt = (ireq && dreq) ? (last_grant == GNT_I ? GNT_D : GNT_I) : (dreq ? GNT_D : GNT_I);
`else
  gnt_t unused_last_grant;
  assign unused_last_grant = last_grant;
  assign gnt = dreq ? GNT_D : GNT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch reads and data loads/stores
// ports: clk, reset (sync, active-low), bus (mem_arbiter_if.master: stage req/ready, memory req/ack, err)
// MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_pick
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = TMO_DEF
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(TMO + 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  gnt_t gnt_q, gnt_d, pick;
  logic mreq_q, mreq_d, mwe_q, mwe_d, iready_q, iready_d, dready_q, dready_d, err_q, err_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
  logic start, done, rd_ok;
  // gnt_q is the current grant and also serves as last_grant once the access completes
  mem_arb_pick u_pick (.ireq(bus.ireq), .dreq(bus.dreq), .last_grant(gnt_q), .gnt(pick));
  assign start = state_q == IDLE && (bus.ireq || bus.dreq);
  // mack wins over a timeout landing in the same cycle
  assign done  = state_q == BUSY && (bus.mack || cnt_q == CW'(TMO - 1));
  assign rd_ok = state_q == BUSY && bus.mack && !mwe_q;
  always_comb begin
    state_d  = start ? BUSY : done ? RESP : state_q == BUSY ? BUSY : IDLE;
    cnt_d    = start ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
    gnt_d    = start ? pick : gnt_q;
    mreq_d   = start ? 1'b1 : done ? 1'b0 : mreq_q;
    maddr_d  = start ? (pick == GNT_D ? bus.daddr : bus.iaddr) : maddr_q;
    mwe_d    = start ? (pick == GNT_D && bus.dwe) : mwe_q;
    mwdata_d = start ? bus.dwdata : mwdata_q;
    irdata_d = rd_ok && gnt_q == GNT_I ? bus.mrdata : irdata_q;
    drdata_d = rd_ok && gnt_q == GNT_D ? bus.mrdata : drdata_q;
    iready_d = done && gnt_q == GNT_I;
    dready_d = done && gnt_q == GNT_D;
    err_d    = err_q || (done && !bus.mack);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= GNT_I;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      err_q    <= err_d;
    end
  end
  assign bus.mreq   = mreq_q;
  assign bus.mwe    = mwe_q;
  assign bus.maddr  = maddr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.irdata = irdata_q;
  assign bus.drdata = drdata_q;
  assign bus.iready = iready_q;
  assign bus.dready = dready_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;
  logic exp_err = 1'b0;
  gnt_t last = GNT_I;
  mem_arbiter_if #(.AW(32), .DW(32)) b();
  mem_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic gnt_t model_pick(input logic i, input logic d);
`ifdef MEM_ARB_RR_EN
    if (i && d) return last == GNT_I ? GNT_D : GNT_I;
`endif
    return d ? GNT_D : GNT_I;
  endfunction
  task automatic zero_check(input string tag);
    check({tag, "_mreq"}, b.mreq, 0);
    check({tag, "_mwe"}, b.mwe, 0);
    check({tag, "_maddr"}, b.maddr, 0);
    check({tag, "_mwdata"}, b.mwdata, 0);
    check({tag, "_irdata"}, b.irdata, 0);
    check({tag, "_drdata"}, b.drdata, 0);
    check({tag, "_iready"}, b.iready, 0);
    check({tag, "_dready"}, b.dready, 0);
    check({tag, "_err"}, b.err, 0);
  endtask
  // Called in an IDLE cycle with requests already driven; memory acks at BUSY cycle d (d > TMO: never)
  task automatic run_xact(input int d, input logic [31:0] rd);
    gnt_t w;
    logic [31:0] ea, ew;
    logic ewe;
    int n;
    w   = model_pick(b.ireq, b.dreq);
    ea  = w == GNT_D ? b.daddr : b.iaddr;
    ewe = w == GNT_D && b.dwe;
    ew  = b.dwdata;
    n   = d > TMO ? TMO : d;
    for (int c = 1; c <= n; c++) begin
      step();
      check("busy_mreq", b.mreq, 1);
      check("busy_maddr", b.maddr, ea);
      check("busy_mwe", b.mwe, ewe);
      if (ewe) check("busy_mwdata", b.mwdata, ew);
      check("busy_iready", b.iready, 0);
      check("busy_dready", b.dready, 0);
      check("busy_irdata", b.irdata, exp_i);
      check("busy_drdata", b.drdata, exp_d);
      if (c == d) begin
        b.mack = 1'b1;
        b.mrdata = rd;
      end
    end
    step();
    b.mack = 1'b0;
    b.mrdata = $urandom;
    if (d > TMO) exp_err = 1'b1;
    else if (!ewe && w == GNT_I) exp_i = rd;
    else if (!ewe) exp_d = rd;
    last = w;
    check("resp_iready", b.iready, w == GNT_I);
    check("resp_dready", b.dready, w == GNT_D);
    check("resp_irdata", b.irdata, exp_i);
    check("resp_drdata", b.drdata, exp_d);
    check("resp_err", b.err, exp_err);
    check("resp_mreq", b.mreq, 0);
    if (w == GNT_I) b.ireq = 1'b0;
    else b.dreq = 1'b0;
    step();
    check("idle_ready", b.iready | b.dready, 0);
  endtask
  initial begin
    b.ireq = 0; b.dreq = 0; b.dwe = 0; b.iaddr = 0; b.daddr = 0; b.dwdata = 0;
    b.mrdata = 0; b.mack = 0;
    step();
    step();
    zero_check("rst");
    reset = 1'b1;
    step();
    b.ireq = 1; b.iaddr = 32'h40;
    run_xact(2, 32'hDEADBEEF);
    b.dreq = 1; b.dwe = 1; b.daddr = 32'h100; b.dwdata = 32'h12345678;
    run_xact(1, 32'hCAFEF00D);
    b.dwe = 0; b.iaddr = 32'h200; b.daddr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      b.ireq = 1; b.dreq = 1;
      run_xact(1, 32'hA5A50000 + k);
    end
    b.ireq = 0; b.dreq = 0;
    step();
    b.mack = 1; b.mrdata = 32'h11111111;
    step();
    b.mack = 0;
    check("spur_mreq", b.mreq, 0);
    check("spur_ready", b.iready | b.dready, 0);
    step();
    check("spur_ready2", b.iready | b.dready, 0);
    check("spur_drdata", b.drdata, exp_d);
    b.dreq = 1; b.dwe = 0; b.daddr = 32'h500;
    run_xact(TMO + 1, 32'h0);
    repeat (10) step();
    check("tmo_sticky", b.err, 1);
    check("tmo_mreq", b.mreq, 0);
    b.dreq = 1; b.dwe = 0; b.daddr = 32'h44;
    step();
    check("rm_mreq", b.mreq, 1);
    reset = 0; b.dreq = 0;
    step();
    zero_check("rm");
    reset = 1; b.mack = 1; b.mrdata = 32'hFFFF0000;
    step();
    b.mack = 0;
    check("rm_late_ready", b.iready | b.dready, 0);
    check("rm_late_mreq", b.mreq, 0);
    check("rm_late_drdata", b.drdata, 0);
    step();
    check("rm_late_ready2", b.iready | b.dready, 0);
    exp_i = '0; exp_d = '0; exp_err = 1'b0; last = GNT_I;
    for (int t = 0; t < 120; t++) begin
      if (!b.ireq && $urandom_range(0, 1) == 1) begin
        b.ireq = 1; b.iaddr = $urandom;
      end
      if (!b.dreq && $urandom_range(0, 1) == 1) begin
        b.dreq = 1; b.dwe = 1'($urandom_range(0, 1)); b.daddr = $urandom; b.dwdata = $urandom;
      end
      if (!b.ireq && !b.dreq) begin
        b.ireq = 1; b.iaddr = $urandom;
      end
      run_xact($urandom_range(0, 11) == 0 ? TMO + 1 : $urandom_range(1, TMO), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
